proc_ctrl_seq: RTL and testbench

Parametrised multi-cycle control sequencer for the single-issue processor. It replaces the fixed-timing state machine and control path.
- Walks FETCH, DECODE, EXE, MEM, WB per instruction.
- Stalls on a memory READY handshake.
- Holds EXE for a configurable number of cycles on multi-cycle ALU ops (mul, div).
- Drives a compact registered control bundle to the data path, register file and memory.

---
 rtl/proc_ctrl_seq_pkg.sv | 75 +++++++
 rtl/proc_ctrl_decode.sv | 79 +++++++
 rtl/proc_ctrl_seq.sv | 184 ++++++++++++++++++
 tb/tb_proc_ctrl_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_seq_pkg.sv
// Shared definitions for the proc_ctrl_seq sequencer: state codes, opcode/funct
// constants, control-field encodings and the EXE latency helper.
package proc_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    PROC_FETCH  = 3'd0,
    PROC_DECODE = 3'd1,
    PROC_EXE    = 3'd2,
    PROC_MEM    = 3'd3,
    PROC_WB     = 3'd4,
    PROC_TRAP   = 3'd5
  } proc_state_e;

  typedef enum logic [2:0] {
    BrNone,
    BrBeq,
    BrBne,
    BrJump,
    BrJr
  } br_type_e;

  // Opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_JMP   = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_PUSH  = 6'h1b;
  localparam logic [5:0] OPC_POP   = 6'h1c;
  localparam logic [5:0] OPC_MULI  = 6'h1d;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_DIV = 6'h28;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  // Register-file destination select
  localparam logic [1:0] RF_DST_RT  = 2'b00;
  localparam logic [1:0] RF_DST_RD  = 2'b01;
  localparam logic [1:0] RF_DST_R31 = 2'b10;

  // Write-back source select
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC1 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [1:0] PC_SEL_REG = 2'b11;

  // Number of EXE cycles for an instruction class; div wins over mul.
  function automatic int unsigned exe_latency(input logic is_mul, input logic is_div,
                                              input int unsigned lat_mul,
                                              input int unsigned lat_div);
    if (is_div) return lat_div;
    if (is_mul) return lat_mul;
    return 1;
  endfunction

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational instruction classifier for proc_ctrl_seq. Produces memory/ALU
// class flags, write-back fields and the branch type from opcode and funct.
module proc_ctrl_decode
  import proc_ctrl_seq_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic       is_mem_rd_o,
  output logic       is_mem_wr_o,
  output logic       is_mul_o,
  output logic       is_div_o,
  output logic       is_illegal_o,
  output logic       rf_we_o,
  output logic [1:0] rf_dst_o,
  output logic [1:0] wb_sel_o,
  output br_type_e   br_type_o
);

  // Decode table; anything unlisted is flagged illegal and otherwise acts as a NOP
  always_comb begin
    is_mem_rd_o  = 1'b0;
    is_mem_wr_o  = 1'b0;
    is_mul_o     = 1'b0;
    is_div_o     = 1'b0;
    is_illegal_o = 1'b0;
    rf_we_o      = 1'b0;
    rf_dst_o     = RF_DST_RT;
    wb_sel_o     = WB_SEL_ALU;
    br_type_o    = BrNone;
    unique case (opcode_i)
      OPC_RTYPE: begin
        unique case (funct_i)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            rf_we_o  = 1'b1;
            rf_dst_o = RF_DST_RD;
          end
          FN_MUL: begin
            rf_we_o  = 1'b1;
            rf_dst_o = RF_DST_RD;
            is_mul_o = 1'b1;
          end
          FN_DIV: begin
            rf_we_o  = 1'b1;
            rf_dst_o = RF_DST_RD;
            is_div_o = 1'b1;
          end
          FN_JR:   br_type_o = BrJr;
          default: is_illegal_o = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_SLTI: rf_we_o = 1'b1;
      OPC_MULI: begin
        rf_we_o  = 1'b1;
        is_mul_o = 1'b1;
      end
      OPC_LUI: begin
        rf_we_o  = 1'b1;
        wb_sel_o = WB_SEL_IMM;
      end
      OPC_LW, OPC_POP: begin
        is_mem_rd_o = 1'b1;
        rf_we_o     = 1'b1;
        wb_sel_o    = WB_SEL_MEM;
      end
      OPC_SW, OPC_PUSH: is_mem_wr_o = 1'b1;
      OPC_JAL: begin
        rf_we_o   = 1'b1;
        rf_dst_o  = RF_DST_R31;
        wb_sel_o  = WB_SEL_PC1;
        br_type_o = BrJump;
      end
      OPC_JMP: br_type_o = BrJump;
      OPC_BEQ: br_type_o = BrBeq;
      OPC_BNE: br_type_o = BrBne;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_ctrl_seq.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXE -> MEM -> WB with READY
// stalls and multi-cycle EXE for mul/div. All outputs are registered.
// Optional feature macro PROC_ILLEGAL_TRAP_EN: illegal instructions park the
// sequencer in TRAP until reset; otherwise they retire as NOPs.
module proc_ctrl_seq
  import proc_ctrl_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned EXE_LAT_MUL = 4,
  parameter int unsigned EXE_LAT_DIV = 32,
  parameter int unsigned LAT_CNT_W   = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] INSTRUCTION,
  input  logic                  ZERO,
  input  logic                  READY,
  output logic                  READ,
  output logic                  WRITE,
  output logic [2:0]            STATE,
  output logic [DATA_WIDTH-1:0] INST,
  output logic                  IR_LOAD,
  output logic                  ALU_START,
  output logic                  RF_WE,
  output logic [1:0]            RF_DST,
  output logic [1:0]            WB_SEL,
  output logic                  PC_LOAD,
  output logic [1:0]            PC_SEL,
  output logic                  RETIRED
);

`ifdef PROC_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  proc_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic read_q, read_d, write_q, write_d, ir_load_q, ir_load_d;
  logic alu_start_q, alu_start_d, rf_we_q, rf_we_d, pc_load_q, pc_load_d;
  logic retired_q, retired_d;
  logic [1:0] rf_dst_q, rf_dst_d, wb_sel_q, wb_sel_d, pc_sel_q, pc_sel_d;

  logic       is_mem_rd, is_mem_wr, is_mul, is_div, is_illegal, dec_rf_we;
  logic [1:0] dec_rf_dst, dec_wb_sel;
  br_type_e   br_type;
  logic       mem_done;

  proc_ctrl_decode u_decode (
    .opcode_i     (inst_q[DATA_WIDTH-1 -: 6]),
    .funct_i      (inst_q[5:0]),
    .is_mem_rd_o  (is_mem_rd),
    .is_mem_wr_o  (is_mem_wr),
    .is_mul_o     (is_mul),
    .is_div_o     (is_div),
    .is_illegal_o (is_illegal),
    .rf_we_o      (dec_rf_we),
    .rf_dst_o     (dec_rf_dst),
    .wb_sel_o     (dec_wb_sel),
    .br_type_o    (br_type)
  );

  // READY only counts while a request is actually outstanding
  assign mem_done = !(is_mem_rd || is_mem_wr) || ((read_q || write_q) && READY);

  // State, counter, instruction and output registers; synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= PROC_FETCH;
      cnt_q       <= '0;
      inst_q      <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      ir_load_q   <= 1'b0;
      alu_start_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_dst_q    <= RF_DST_RT;
      wb_sel_q    <= WB_SEL_ALU;
      pc_load_q   <= 1'b0;
      pc_sel_q    <= PC_SEL_INC;
      retired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inst_q      <= inst_d;
      read_q      <= read_d;
      write_q     <= write_d;
      ir_load_q   <= ir_load_d;
      alu_start_q <= alu_start_d;
      rf_we_q     <= rf_we_d;
      rf_dst_q    <= rf_dst_d;
      wb_sel_q    <= wb_sel_d;
      pc_load_q   <= pc_load_d;
      pc_sel_q    <= pc_sel_d;
      retired_q   <= retired_d;
    end
  end

  // Next state, EXE latency counter and instruction capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    unique case (state_q)
      PROC_FETCH: begin
        // READ is low for the one cycle after reset, so READY is ignored then
        if (read_q && READY) begin
          state_d = PROC_DECODE;
          inst_d  = INSTRUCTION;
        end
      end
      PROC_DECODE: begin
        if (TrapEn && is_illegal) begin
          state_d = PROC_TRAP;
        end else begin
          state_d = PROC_EXE;
          cnt_d   = LAT_CNT_W'(exe_latency(is_mul, is_div, EXE_LAT_MUL, EXE_LAT_DIV));
        end
      end
      PROC_EXE: begin
        if (cnt_q <= LAT_CNT_W'(1)) begin
          state_d = PROC_MEM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      PROC_MEM: if (mem_done) state_d = PROC_WB;
      PROC_WB:   state_d = PROC_FETCH;
      PROC_TRAP: state_d = PROC_TRAP;
      default:   state_d = PROC_FETCH;
    endcase
  end

  // Next registered outputs, derived from the state being entered
  always_comb begin
    read_d      = 1'b0;
    write_d     = 1'b0;
    ir_load_d   = (state_q == PROC_FETCH) && (state_d == PROC_DECODE);
    alu_start_d = (state_q == PROC_DECODE) && (state_d == PROC_EXE);
    rf_we_d     = 1'b0;
    rf_dst_d    = RF_DST_RT;
    wb_sel_d    = WB_SEL_ALU;
    pc_load_d   = 1'b0;
    pc_sel_d    = PC_SEL_INC;
    retired_d   = 1'b0;
    if (state_d == PROC_FETCH) read_d = 1'b1;
    if (state_d == PROC_MEM) begin
      read_d  = is_mem_rd;
      write_d = is_mem_wr;
    end
    if (state_d == PROC_WB) begin
      retired_d = 1'b1;
      pc_load_d = 1'b1;
      rf_we_d   = dec_rf_we;
      rf_dst_d  = dec_rf_dst;
      wb_sel_d  = dec_wb_sel;
      // ZERO is taken on the edge that enters WB, so PC_SEL is valid throughout WB
      unique case (br_type)
        BrBeq:   pc_sel_d = ZERO ? PC_SEL_BR : PC_SEL_INC;
        BrBne:   pc_sel_d = ZERO ? PC_SEL_INC : PC_SEL_BR;
        BrJump:  pc_sel_d = PC_SEL_JMP;
        BrJr:    pc_sel_d = PC_SEL_REG;
        default: pc_sel_d = PC_SEL_INC;
      endcase
    end
  end

  assign STATE     = state_q;
  assign INST      = inst_q;
  assign READ      = read_q;
  assign WRITE     = write_q;
  assign IR_LOAD   = ir_load_q;
  assign ALU_START = alu_start_q;
  assign RF_WE     = rf_we_q;
  assign RF_DST    = rf_dst_q;
  assign WB_SEL    = wb_sel_q;
  assign PC_LOAD   = pc_load_q;
  assign PC_SEL    = pc_sel_q;
  assign RETIRED   = retired_q;

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// Self-checking bench for proc_ctrl_seq: directed cases followed by random
// instructions, delays and ZERO values, checked cycle by cycle against a
// per-mnemonic table of expected behaviour.
module tb_proc_ctrl_seq;

`ifdef PROC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        ZERO = 1'b0;
  logic        READY = 1'b0;
  logic        READ, WRITE, IR_LOAD, ALU_START, RF_WE, PC_LOAD, RETIRED;
  logic [2:0]  STATE;
  logic [31:0] INST;
  logic [1:0]  RF_DST, WB_SEL, PC_SEL;

  proc_ctrl_seq #(
    .DATA_WIDTH  (32),
    .EXE_LAT_MUL (4),
    .EXE_LAT_DIV (32),
    .LAT_CNT_W   (6)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSTRUCTION (INSTRUCTION),
    .ZERO        (ZERO),
    .READY       (READY),
    .READ        (READ),
    .WRITE       (WRITE),
    .STATE       (STATE),
    .INST        (INST),
    .IR_LOAD     (IR_LOAD),
    .ALU_START   (ALU_START),
    .RF_WE       (RF_WE),
    .RF_DST      (RF_DST),
    .WB_SEL      (WB_SEL),
    .PC_LOAD     (PC_LOAD),
    .PC_SEL      (PC_SEL),
    .RETIRED     (RETIRED)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected behaviour of one mnemonic
  typedef struct {
    string      name;
    logic [5:0] opc;
    logic [5:0] fn;
    bit         illegal;
    bit         rd;
    bit         wr;
    int         lat;
    bit         we;
    logic [1:0] dst;
    logic [1:0] wsel;
    logic [1:0] pc_z1;
    logic [1:0] pc_z0;
  } op_t;

  op_t ops[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic op_t mk(input string name, input logic [5:0] opc, input logic [5:0] fn,
                             input bit illegal, input bit rd, input bit wr, input int lat,
                             input bit we, input logic [1:0] dst, input logic [1:0] wsel,
                             input logic [1:0] pc_z1, input logic [1:0] pc_z0);
    op_t o;
    o.name = name; o.opc = opc; o.fn = fn; o.illegal = illegal; o.rd = rd; o.wr = wr;
    o.lat = lat; o.we = we; o.dst = dst; o.wsel = wsel; o.pc_z1 = pc_z1; o.pc_z0 = pc_z0;
    return o;
  endfunction

  function automatic op_t find_op(input string name);
    foreach (ops[i]) if (ops[i].name == name) return ops[i];
    return ops[0];
  endfunction

  function automatic logic [31:0] mk_inst(input op_t o);
    logic [31:0] r;
    r = $urandom;
    r[31:26] = o.opc;
    if (o.opc == 6'h00) r[5:0] = o.fn;
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_state"}, 32'(STATE), 32'd0);
    check_eq({tag, "_inst"}, INST, 32'd0);
    check_eq({tag, "_outs"}, 32'({READ, WRITE, IR_LOAD, ALU_START, RF_WE, RF_DST, WB_SEL,
                                  PC_LOAD, PC_SEL, RETIRED}), 32'd0);
  endtask

  task automatic do_reset();
    RST   = 1'b0;
    READY = 1'($urandom_range(0, 1));
    tick();
    check_reset_state("rst");
    RST = 1'b1;
    tick();
  endtask

  // Runs one instruction starting just after the edge that entered FETCH
  task automatic run_op(input op_t o, input int fdly, input int mdly, input bit zero,
                        input bit rst_in_mem);
    logic [31:0] inst;
    inst = mk_inst(o);
    ZERO = zero;
    for (int c = 0; c <= fdly; c++) begin
      check_eq("fetch_state", 32'(STATE), 32'd0);
      check_eq("fetch_read", 32'(READ), 32'd1);
      check_eq("fetch_idle", 32'({WRITE, RETIRED, RF_WE, ALU_START}), 32'd0);
      READY       = (c == fdly);
      INSTRUCTION = (c == fdly) ? inst : 32'($urandom);
      tick();
    end
    check_eq("dec_state", 32'(STATE), 32'd1);
    check_eq("dec_ir_load", 32'(IR_LOAD), 32'd1);
    check_eq("dec_inst", INST, inst);
    check_eq("dec_read", 32'({READ, WRITE}), 32'd0);
    READY       = 1'($urandom_range(0, 1));
    INSTRUCTION = $urandom;
    tick();
    if (o.illegal && TRAP_EN) begin
      for (int k = 0; k < 100; k++) begin
        check_eq("trap_state", 32'(STATE), 32'd5);
        check_eq("trap_outs", 32'({READ, WRITE, RETIRED, IR_LOAD, ALU_START, PC_LOAD, RF_WE}),
                 32'd0);
        READY = 1'($urandom_range(0, 1));
        tick();
      end
      do_reset();
      return;
    end
    for (int k = 0; k < o.lat; k++) begin
      check_eq("exe_state", 32'(STATE), 32'd2);
      check_eq("exe_alu_start", 32'(ALU_START), 32'(k == 0));
      check_eq("exe_idle", 32'({READ, WRITE, IR_LOAD, RETIRED}), 32'd0);
      READY = 1'($urandom_range(0, 1));
      tick();
    end
    if (o.rd || o.wr) begin
      for (int c = 0; c <= mdly; c++) begin
        check_eq("mem_state", 32'(STATE), 32'd3);
        check_eq("mem_read", 32'(READ), 32'(o.rd));
        check_eq("mem_write", 32'(WRITE), 32'(o.wr));
        if (rst_in_mem) begin
          READY = 1'b0;
          RST   = 1'b0;
          tick();
          check_reset_state("rst_mem");
          RST = 1'b1;
          tick();
          return;
        end
        READY = (c == mdly);
        tick();
      end
    end else begin
      check_eq("mem_state", 32'(STATE), 32'd3);
      check_eq("mem_noreq", 32'({READ, WRITE}), 32'd0);
      READY = 1'($urandom_range(0, 1));
      tick();
    end
    check_eq("wb_state", 32'(STATE), 32'd4);
    check_eq("wb_retired", 32'(RETIRED), 32'd1);
    check_eq("wb_pc_load", 32'(PC_LOAD), 32'd1);
    check_eq("wb_rf_we", 32'(RF_WE), 32'(o.we));
    if (o.we) begin
      check_eq("wb_rf_dst", 32'(RF_DST), 32'(o.dst));
      check_eq("wb_sel", 32'(WB_SEL), 32'(o.wsel));
    end
    check_eq("wb_pc_sel", 32'(PC_SEL), 32'(zero ? o.pc_z1 : o.pc_z0));
    check_eq("wb_idle", 32'({READ, WRITE, ALU_START}), 32'd0);
    READY = 1'($urandom_range(0, 1));
    tick();
  endtask

  initial begin
    //                 name    opc    fn     ill rd wr lat we dst    wsel   pc_z1  pc_z0
    ops.push_back(mk("add",  6'h00, 6'h20, 0, 0, 0, 1,  1, 2'b01, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("sub",  6'h00, 6'h22, 0, 0, 0, 1,  1, 2'b01, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("and",  6'h00, 6'h24, 0, 0, 0, 1,  1, 2'b01, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("or",   6'h00, 6'h25, 0, 0, 0, 1,  1, 2'b01, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("slt",  6'h00, 6'h2a, 0, 0, 0, 1,  1, 2'b01, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("div",  6'h00, 6'h28, 0, 0, 0, 32, 1, 2'b01, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("mul",  6'h00, 6'h2c, 0, 0, 0, 4,  1, 2'b01, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("jr",   6'h00, 6'h08, 0, 0, 0, 1,  0, 2'b00, 2'b00, 2'b11, 2'b11));
    ops.push_back(mk("addi", 6'h08, 6'h00, 0, 0, 0, 1,  1, 2'b00, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("andi", 6'h0c, 6'h00, 0, 0, 0, 1,  1, 2'b00, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("ori",  6'h0d, 6'h00, 0, 0, 0, 1,  1, 2'b00, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("slti", 6'h0a, 6'h00, 0, 0, 0, 1,  1, 2'b00, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("muli", 6'h1d, 6'h00, 0, 0, 0, 4,  1, 2'b00, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("lui",  6'h0f, 6'h00, 0, 0, 0, 1,  1, 2'b00, 2'b11, 2'b00, 2'b00));
    ops.push_back(mk("lw",   6'h23, 6'h00, 0, 1, 0, 1,  1, 2'b00, 2'b01, 2'b00, 2'b00));
    ops.push_back(mk("pop",  6'h1c, 6'h00, 0, 1, 0, 1,  1, 2'b00, 2'b01, 2'b00, 2'b00));
    ops.push_back(mk("sw",   6'h2b, 6'h00, 0, 0, 1, 1,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("push", 6'h1b, 6'h00, 0, 0, 1, 1,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("jal",  6'h03, 6'h00, 0, 0, 0, 1,  1, 2'b10, 2'b10, 2'b10, 2'b10));
    ops.push_back(mk("jmp",  6'h02, 6'h00, 0, 0, 0, 1,  0, 2'b00, 2'b00, 2'b10, 2'b10));
    ops.push_back(mk("beq",  6'h04, 6'h00, 0, 0, 0, 1,  0, 2'b00, 2'b00, 2'b01, 2'b00));
    ops.push_back(mk("bne",  6'h05, 6'h00, 0, 0, 0, 1,  0, 2'b00, 2'b00, 2'b00, 2'b01));
    ops.push_back(mk("ill_op", 6'h3f, 6'h00, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    ops.push_back(mk("ill_fn", 6'h00, 6'h3f, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00));

    RST = 1'b0;
    tick();
    tick();
    check_reset_state("por");
    RST = 1'b1;
    tick();

    run_op(find_op("add"), 0, 0, 1'b0, 1'b0);
    run_op(find_op("add"), 3, 0, 1'b0, 1'b0);
    run_op(find_op("div"), 0, 0, 1'b0, 1'b0);
    run_op(find_op("mul"), 1, 0, 1'b1, 1'b0);
    run_op(find_op("beq"), 0, 0, 1'b1, 1'b0);
    run_op(find_op("beq"), 0, 0, 1'b0, 1'b0);
    run_op(find_op("bne"), 0, 0, 1'b1, 1'b0);
    run_op(find_op("bne"), 0, 0, 1'b0, 1'b0);
    run_op(find_op("sw"), 0, 2, 1'b0, 1'b0);
    run_op(find_op("lw"), 1, 5, 1'b0, 1'b1);
    run_op(find_op("lw"), 0, 1, 1'b0, 1'b0);
    run_op(find_op("ill_op"), 0, 0, 1'b0, 1'b0);
    run_op(find_op("ill_fn"), 2, 0, 1'b1, 1'b0);
    run_op(find_op("jal"), 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      run_op(ops[$urandom_range(0, ops.size() - 1)], $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
